// File: rtl/utm_pkg.sv
// Shared widths, direction encoding, sequencer states and symbol constants
// for the universal Turing machine tape controller.
package utm_pkg;

   localparam int SYM_W   = 3;
   localparam int STATE_W = 3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } fsm_t;

   localparam logic [SYM_W-1:0] SYM_0 = 3'b000;
   localparam logic [SYM_W-1:0] SYM_1 = 3'b001;
   localparam logic [SYM_W-1:0] SYM_2 = 3'b010;
   localparam logic [SYM_W-1:0] SYM_4 = 3'b100;
   localparam logic [SYM_W-1:0] SYM_5 = 3'b101;

endpackage

// File: rtl/utm_tape_ram.sv
// Tape store: flop array with asynchronous clear, one write port and two
// combinational read ports (head read and external readback).
module utm_tape_ram
   import utm_pkg::*;
#(
   parameter int   TAPE_LEN = 32,
   localparam int  AW       = $clog2(TAPE_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [SYM_W-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [SYM_W-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [SYM_W-1:0] rdata_b
);

   logic [SYM_W-1:0] mem [TAPE_LEN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPE_LEN; i++) mem[i] <= SYM_0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/utm_tape_controller.sv
// Turing machine sequencer: FETCH presents {state, symbol} to the external
// transition table, EXEC applies its answer to tape, head and state.
module utm_tape_controller
   import utm_pkg::*;
#(
   parameter int  TAPE_LEN    = 32,
   parameter int  START_POS   = 16,
   parameter int  START_STATE = 0,
   parameter int  HALT_STATE  = 7,
   parameter int  MAX_STEPS   = 255,
   localparam int AW          = $clog2(TAPE_LEN),
   localparam int SW          = $clog2(MAX_STEPS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [SYM_W-1:0]   load_sym,
   output logic [SYM_W-1:0]   rd_sym,
   input  logic               start,
   output logic [STATE_W-1:0] tt_state,
   output logic [SYM_W-1:0]   tt_sym,
   input  logic [STATE_W-1:0] tt_next_state,
   input  logic [SYM_W-1:0]   tt_new_sym,
   input  logic               tt_dir,
   output logic [AW-1:0]      head_pos,
   output logic [SW-1:0]      step_count,
   output logic               busy,
   output logic               halted,
   output logic               fault,
   output logic               timeout,
   output logic [1:0]         fsm_dbg
);

   // Handshake: start and load_en are one-cycle requests accepted only on a
   // rising edge where busy is low; a load in the same cycle as start lands first.

   fsm_t               fsm_q, fsm_d;
   logic [STATE_W-1:0] cur_state;
   logic [SYM_W-1:0]   head_sym;
   logic [AW-1:0]      head_moved;
   logic [SW-1:0]      step_inc;
   logic               move_ok, halt_hit, step_max, run_start;
   logic               ram_we;
   logic [AW-1:0]      ram_waddr;
   logic [SYM_W-1:0]   ram_wdata;

   assign halt_hit   = (tt_next_state == STATE_W'(HALT_STATE));
   assign move_ok    = (tt_dir == DIR_RIGHT) ? (head_pos != AW'(TAPE_LEN - 1))
                                             : (head_pos != '0);
   assign head_moved = (tt_dir == DIR_RIGHT) ? head_pos + AW'(1) : head_pos - AW'(1);
   assign step_inc   = step_count + SW'(1);
   assign step_max   = (step_inc == SW'(MAX_STEPS));
   assign fsm_dbg    = fsm_q;

   utm_tape_ram #(.TAPE_LEN(TAPE_LEN)) u_tape (
      .clk     (clk),
      .reset   (reset),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr_a (head_pos),
      .rdata_a (head_sym),
      .raddr_b (load_addr),
      .rdata_b (rd_sym)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fsm_q <= IDLE;
      else       fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE, DONE: if (start) fsm_d = FETCH;
         FETCH:      fsm_d = EXEC;
         EXEC:       fsm_d = (halt_hit || !move_ok || step_max) ? DONE : FETCH;
         default:    fsm_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (fsm_q == FETCH) || (fsm_q == EXEC);
      run_start = !busy && start;
      ram_we    = 1'b0;
      ram_waddr = load_addr;
      ram_wdata = load_sym;
      if (fsm_q == EXEC) begin
         ram_we    = 1'b1;
         ram_waddr = head_pos;
         ram_wdata = tt_new_sym;
      end else if (!busy && load_en) begin
         ram_we    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_pos   <= AW'(START_POS);
         cur_state  <= STATE_W'(START_STATE);
         tt_state   <= STATE_W'(START_STATE);
         tt_sym     <= SYM_0;
         step_count <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         if (run_start) begin
            head_pos   <= AW'(START_POS);
            cur_state  <= STATE_W'(START_STATE);
            step_count <= '0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
         end
         if (fsm_q == FETCH) begin
            tt_state <= cur_state;
            tt_sym   <= head_sym;
         end
         if (fsm_q == EXEC) begin
            cur_state  <= tt_next_state;
            step_count <= step_inc;
            if (move_ok) head_pos <= head_moved;
            // Halt outranks an edge fault; either outranks the step limit.
            halted  <= halt_hit;
            fault   <= !halt_hit && !move_ok;
            timeout <= !halt_hit && move_ok && step_max;
         end
      end
   end

endmodule

// File: tb/tb_utm_tape_controller.sv
// Bench for utm_tape_controller: behavioural transition-table stubs, directed
// runs, and a run-completion scoreboard fed by the stimulus process.
module tb_utm_tape_controller;
   import utm_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (MAX_STEPS = 255)
   logic       reset = 1'b1, load_en = 1'b0, start = 1'b0;
   logic [4:0] load_addr = '0;
   logic [2:0] load_sym = '0, rd_sym, tt_state, tt_sym, tt_next_state, tt_new_sym;
   logic       tt_dir, busy, halted, fault, timeout;
   logic [4:0] head_pos;
   logic [7:0] step_count;
   logic [1:0] fsm_dbg;
   int         stub_mode = 0;

   // Short instance (MAX_STEPS = 8)
   logic       reset8 = 1'b1, start8 = 1'b0;
   logic [4:0] load_addr8 = '0;
   logic [2:0] rd_sym8, tt_state8, tt_sym8, tt_next_state8, tt_new_sym8;
   logic       tt_dir8, busy8, halted8, fault8, timeout8;
   logic [4:0] head_pos8;
   logic [3:0] step_count8;
   logic [1:0] fsm_dbg8;

   utm_tape_controller #(.TAPE_LEN(32), .START_POS(16), .START_STATE(0),
                         .HALT_STATE(7), .MAX_STEPS(255)) u_dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_sym(load_sym), .rd_sym(rd_sym), .start(start), .tt_state(tt_state),
      .tt_sym(tt_sym), .tt_next_state(tt_next_state), .tt_new_sym(tt_new_sym),
      .tt_dir(tt_dir), .head_pos(head_pos), .step_count(step_count), .busy(busy),
      .halted(halted), .fault(fault), .timeout(timeout), .fsm_dbg(fsm_dbg)
   );

   utm_tape_controller #(.TAPE_LEN(32), .START_POS(16), .START_STATE(0),
                         .HALT_STATE(7), .MAX_STEPS(8)) u_dut8 (
      .clk(clk), .reset(reset8), .load_en(1'b0), .load_addr(load_addr8),
      .load_sym(3'b000), .rd_sym(rd_sym8), .start(start8), .tt_state(tt_state8),
      .tt_sym(tt_sym8), .tt_next_state(tt_next_state8), .tt_new_sym(tt_new_sym8),
      .tt_dir(tt_dir8), .head_pos(head_pos8), .step_count(step_count8), .busy(busy8),
      .halted(halted8), .fault(fault8), .timeout(timeout8), .fsm_dbg(fsm_dbg8)
   );

   // Transition table stubs
   always_comb begin
      tt_next_state = 3'd0;
      tt_new_sym    = SYM_0;
      tt_dir        = DIR_LEFT;
      case (stub_mode)
         1: begin
            tt_new_sym = SYM_4;
            tt_dir     = DIR_RIGHT;
            case (tt_state)
               3'd0:    tt_next_state = 3'd1;
               3'd1:    tt_next_state = 3'd2;
               default: tt_next_state = 3'd7;
            endcase
         end
         2: begin
            tt_next_state = 3'd1;
            tt_new_sym    = SYM_2;
         end
         3: begin
            tt_next_state = (head_pos == 5'd0) ? 3'd7 : 3'd1;
            tt_new_sym    = SYM_5;
         end
         default: ;
      endcase
   end

   assign tt_next_state8 = 3'd1;
   assign tt_new_sym8    = SYM_1;
   assign tt_dir8        = (head_pos8 == 5'd16) ? DIR_RIGHT : DIR_LEFT;

   // Scoreboard: {halted, fault, timeout, step_count[7:0], head_pos[4:0]}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp8_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic prev_busy = 1'b0, prev_busy8 = 1'b0;

   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      if (reset) prev_busy = 1'b0;
      else begin
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) check("run_end_unexpected", 1, 0);
            else begin
               exp_v = exp_q.pop_front();
               check("run_end_status", {halted, fault, timeout, step_count, head_pos}, exp_v);
            end
         end
         prev_busy = busy;
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      if (reset8) prev_busy8 = 1'b0;
      else begin
         if (prev_busy8 && !busy8) begin
            if (exp8_q.size() == 0) check("run8_end_unexpected", 1, 0);
            else begin
               exp_v = exp8_q.pop_front();
               check("run8_end_status",
                     {halted8, fault8, timeout8, 4'b0, step_count8, head_pos8}, exp_v);
            end
         end
         prev_busy8 = busy8;
      end
   end

   // Driver tasks
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic load(input logic [4:0] a, input logic [2:0] s);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_sym = s;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [4:0] a, input logic [2:0] s);
      load_addr = a;
      #1;
      check(name, rd_sym, s);
   endtask

   task automatic wait_idle(input bit short_dut);
      int n;
      n = 0;
      while ((short_dut ? busy8 : busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("run_finish_bound", (n < 200), 1);
   endtask

   initial begin
      // Reset
      repeat (2) @(negedge clk);
      reset = 1'b0; reset8 = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_fault_timeout", {fault, timeout}, 0);
      check("rst_head", head_pos, 16);
      check("rst_tt_state", tt_state, 0);
      check("rst_step", step_count, 0);
      for (int i = 0; i < 32; i++) read_check("rst_tape", 5'(i), SYM_0);

      // Preload and readback
      load(5'd16, SYM_1);
      read_check("load_readback", 5'd16, SYM_1);

      // First run: A,001 -> B,100,R ... halts entering state 7 on step 3
      stub_mode = 1;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 8'd3, 5'd19});
      pulse_start();                          // now in FETCH
      @(negedge clk);                         // EXEC of step 1
      check("step1_tt_sym", tt_sym, SYM_1);
      check("step1_tt_state", tt_state, 0);
      @(negedge clk);                         // step 1 committed
      read_check("step1_tape16", 5'd16, SYM_4);
      check("step1_head", head_pos, 17);
      check("step1_count", step_count, 1);
      @(negedge clk);                         // FETCH of step 2 done
      check("step2_tt_state", tt_state, 1);
      load_en = 1'b1; load_addr = 5'd20; load_sym = SYM_5;
      @(negedge clk);
      load_en = 1'b0; load_addr = 5'd16;
      wait_idle(0);
      check("halt_busy", busy, 0);
      check("halt_flag", halted, 1);
      read_check("busy_load_ignored", 5'd20, SYM_0);
      read_check("step3_tape18", 5'd18, SYM_4);

      // Rerun with a load committed in the same cycle as start
      exp_q.push_back({1'b1, 1'b0, 1'b0, 8'd3, 5'd19});
      @(negedge clk);
      load_en = 1'b1; load_addr = 5'd16; load_sym = SYM_5; start = 1'b1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      check("rerun_halted_clr", halted, 0);
      check("rerun_head", head_pos, 16);
      check("rerun_step", step_count, 0);
      @(negedge clk);
      check("rerun_tt_sym_load", tt_sym, SYM_5);
      wait_idle(0);

      // Walk left off the tape edge
      stub_mode = 2;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 8'd17, 5'd0});
      pulse_start();
      wait_idle(0);
      check("edge_fault", fault, 1);
      read_check("edge_tape0", 5'd0, SYM_2);
      read_check("edge_tape1", 5'd1, SYM_2);

      // Same walk, halting on the illegal move
      stub_mode = 3;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 8'd17, 5'd0});
      pulse_start();
      wait_idle(0);
      check("edge_halt_fault", fault, 0);
      read_check("edge_halt_tape0", 5'd0, SYM_5);

      // Step limit on the short instance
      exp8_q.push_back({1'b0, 1'b0, 1'b1, 8'd8, 5'd16});
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      wait_idle(1);
      check("timeout_flag", timeout8, 1);
      load_addr8 = 5'd17;
      #1;
      check("timeout_tape17", rd_sym8, SYM_1);

      // Reset in the middle of EXEC
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_fsm_exec", fsm_dbg8, EXEC);
      check("mid_step", step_count8, 2);
      load_addr8 = 5'd16;
      reset8 = 1'b1;
      #1;
      check("abort_fsm", fsm_dbg8, IDLE);
      check("abort_busy", busy8, 0);
      check("abort_head", head_pos8, 16);
      check("abort_step", step_count8, 0);
      check("abort_flags", {halted8, fault8, timeout8}, 0);
      check("abort_tt", {tt_state8, tt_sym8}, 0);
      check("abort_tape16", rd_sym8, SYM_0);
      @(negedge clk) reset8 = 1'b0;

      // Report
      repeat (3) @(negedge clk);
      check("scoreboard_drain", exp_q.size() + exp8_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
